// File: rtl/sipo_frame_ctrl.sv
// Serial-in/parallel-out frame controller: gathers WIDTH qualified serial bits,
// then holds the assembled word on a valid/ready port until it is accepted.
module sipo_frame_ctrl #(
    parameter int WIDTH     = 4,
    parameter bit MSB_FIRST = 1'b1,
    localparam int CW       = $clog2(WIDTH + 1)
) (
    input  logic             clk,
    input  logic             clr,
    input  logic             start,
    input  logic             sin,
    input  logic             sin_en,
    output logic [WIDTH-1:0] q,
    output logic             q_valid,
    input  logic             q_ready,
    output logic             busy,
    output logic [CW-1:0]    bit_cnt,
    output logic             overrun
);

    localparam logic [1:0] ST_IDLE  = 2'd0;
    localparam logic [1:0] ST_SHIFT = 2'd1;
    localparam logic [1:0] ST_HOLD  = 2'd2;

    logic [1:0]       state_r;
    logic [WIDTH-1:0] shift_r;

    logic [1:0]       state_s;
    logic [WIDTH-1:0] shift_s;
    logic [WIDTH-1:0] shifted_s;
    logic [WIDTH-1:0] q_s;
    logic             q_valid_s;
    logic             busy_s;
    logic [CW-1:0]    bit_cnt_s;
    logic             overrun_s;

    // Shift register contents after taking in the current serial bit
    always_comb begin
        if (MSB_FIRST) begin
            shifted_s = {shift_r[WIDTH-2:0], sin};
        end else begin
            shifted_s = {sin, shift_r[WIDTH-1:1]};
        end
    end

    // Next-state and next-output logic for the frame sequencer
    always_comb begin
        state_s   = state_r;
        shift_s   = shift_r;
        q_s       = q;
        q_valid_s = q_valid;
        bit_cnt_s = bit_cnt;
        overrun_s = overrun;
        case (state_r)
            ST_IDLE: begin
                if (start) begin
                    state_s   = ST_SHIFT;
                    shift_s   = {WIDTH{1'b0}};
                    bit_cnt_s = {CW{1'b0}};
                end else begin
                    state_s   = ST_IDLE;
                end
            end
            ST_SHIFT: begin
                if (sin_en) begin
                    shift_s = shifted_s;
                    // Last bit of the word: publish it in the same edge
                    if (bit_cnt == CW'(WIDTH - 1)) begin
                        q_s       = shifted_s;
                        q_valid_s = 1'b1;
                        bit_cnt_s = CW'(WIDTH);
                        state_s   = ST_HOLD;
                    end else begin
                        bit_cnt_s = bit_cnt + CW'(1);
                    end
                end else begin
                    state_s = ST_SHIFT;
                end
            end
            ST_HOLD: begin
                if (sin_en) begin
                    overrun_s = 1'b1;
                end else begin
                    overrun_s = overrun;
                end
                if (q_ready) begin
                    q_valid_s = 1'b0;
                    bit_cnt_s = {CW{1'b0}};
                    if (start) begin
                        state_s = ST_SHIFT;
                        shift_s = {WIDTH{1'b0}};
                    end else begin
                        state_s = ST_IDLE;
                    end
                end else begin
                    state_s = ST_HOLD;
                end
            end
            default: begin
                state_s   = ST_IDLE;
                q_valid_s = 1'b0;
                bit_cnt_s = {CW{1'b0}};
            end
        endcase
        busy_s = (state_s != ST_IDLE);
    end

    // State and registered outputs, with synchronous active-low clear
    always_ff @(posedge clk) begin
        if (!clr) begin
            state_r <= ST_IDLE;
            shift_r <= {WIDTH{1'b0}};
            q       <= {WIDTH{1'b0}};
            q_valid <= 1'b0;
            busy    <= 1'b0;
            bit_cnt <= {CW{1'b0}};
            overrun <= 1'b0;
        end else begin
            state_r <= state_s;
            shift_r <= shift_s;
            q       <= q_s;
            q_valid <= q_valid_s;
            busy    <= busy_s;
            bit_cnt <= bit_cnt_s;
            overrun <= overrun_s;
        end
    end

endmodule

// File: tb/tb_sipo_frame_ctrl.sv
// Scoreboard bench for sipo_frame_ctrl: an MSB-first and an LSB-first instance
// share stimulus; each accepted word is popped from a per-instance queue.
module tb_sipo_frame_ctrl;

    logic       clk;
    logic       clr;
    logic       start;
    logic       sin;
    logic       sin_en;
    logic       q_ready;

    logic [3:0] q_m, q_l;
    logic       q_valid_m, q_valid_l;
    logic       busy_m, busy_l;
    logic [2:0] bit_cnt_m, bit_cnt_l;
    logic       overrun_m, overrun_l;

    int n_checks = 0;
    int n_fail   = 0;

    logic [3:0] sb_m[$];
    logic [3:0] sb_l[$];

    sipo_frame_ctrl #(.WIDTH(4), .MSB_FIRST(1'b1)) dut_m (
        .clk(clk), .clr(clr), .start(start), .sin(sin), .sin_en(sin_en),
        .q(q_m), .q_valid(q_valid_m), .q_ready(q_ready), .busy(busy_m),
        .bit_cnt(bit_cnt_m), .overrun(overrun_m)
    );

    sipo_frame_ctrl #(.WIDTH(4), .MSB_FIRST(1'b0)) dut_l (
        .clk(clk), .clr(clr), .start(start), .sin(sin), .sin_en(sin_en),
        .q(q_l), .q_valid(q_valid_l), .q_ready(q_ready), .busy(busy_l),
        .bit_cnt(bit_cnt_l), .overrun(overrun_l)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    // Monitor: a transfer happens where q_valid and q_ready are both high
    always @(negedge clk) begin
        if (clr && q_ready && q_valid_m) begin
            if (sb_m.size() == 0) check("sb_msb_unexpected", 32'd1, 32'd0);
            else check("sb_msb_word", q_m, sb_m.pop_front());
        end
        if (clr && q_ready && q_valid_l) begin
            if (sb_l.size() == 0) check("sb_lsb_unexpected", 32'd1, 32'd0);
            else check("sb_lsb_word", q_l, sb_l.pop_front());
        end
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1, "timeout");
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic pulse_start();
        start = 1'b1; sin_en = 1'b0;
        tick();
        start = 1'b0;
    endtask

    // Four consecutive qualified bits, b[3] first
    task automatic feed4(input logic [3:0] b);
        for (int i = 3; i >= 0; i--) begin
            sin_en = 1'b1; sin = b[i];
            tick();
        end
        sin_en = 1'b0;
    endtask

    task automatic check_both(input string name, input logic qv, input logic bz,
                              input logic [2:0] bc, input logic ov);
        check({name, "_qv_m"}, q_valid_m, qv);  check({name, "_qv_l"}, q_valid_l, qv);
        check({name, "_busy_m"}, busy_m, bz);   check({name, "_busy_l"}, busy_l, bz);
        check({name, "_cnt_m"}, bit_cnt_m, bc); check({name, "_cnt_l"}, bit_cnt_l, bc);
        check({name, "_ovr_m"}, overrun_m, ov); check({name, "_ovr_l"}, overrun_l, ov);
    endtask

    logic [6:0] en_pat  = 7'b1001101;
    logic [6:0] sin_pat = 7'b0111110;
    logic [2:0] cnt_pat [7] = '{3'd1, 3'd1, 3'd1, 3'd2, 3'd3, 3'd3, 3'd4};

    initial begin
        clr = 1'b0; start = 1'b1; sin = 1'b0; sin_en = 1'b1; q_ready = 1'b0;
        // 1: reset dominates start/sin_en
        for (int i = 0; i < 2; i++) begin
            sin = ~sin;
            tick();
        end
        check_both("rst", 1'b0, 1'b0, 3'd0, 1'b0);
        check("rst_q_m", q_m, 4'b0000); check("rst_q_l", q_l, 4'b0000);
        clr = 1'b1; start = 1'b0; sin_en = 1'b1;
        tick(); tick();
        check_both("idle_ign_sin", 1'b0, 1'b0, 3'd0, 1'b0);

        // 2: basic frame 1,0,1,1 with consumer ready
        q_ready = 1'b1;
        sb_m.push_back(4'b1011); sb_l.push_back(4'b1101);
        pulse_start();
        check_both("t2_start", 1'b0, 1'b1, 3'd0, 1'b0);
        feed4(4'b1011);
        check_both("t2_done", 1'b1, 1'b1, 3'd4, 1'b0);
        check("t2_q_m", q_m, 4'b1011); check("t2_q_l", q_l, 4'b1101);
        tick();
        check_both("t2_xfer", 1'b0, 1'b0, 3'd0, 1'b0);

        // 3: gaps in sin_en hold state
        sb_m.push_back(4'b0110); sb_l.push_back(4'b0110);
        pulse_start();
        for (int i = 6; i >= 0; i--) begin
            sin_en = en_pat[i]; sin = sin_pat[i];
            tick();
            check("t3_cnt_m", bit_cnt_m, cnt_pat[6-i]);
            check("t3_cnt_l", bit_cnt_l, cnt_pat[6-i]);
        end
        sin_en = 1'b0;
        check("t3_q_m", q_m, 4'b0110);
        tick();
        check_both("t3_xfer", 1'b0, 1'b0, 3'd0, 1'b0);

        // 4: back-pressure with bits dropped while the word is pending
        q_ready = 1'b0;
        sb_m.push_back(4'b1100); sb_l.push_back(4'b0011);
        pulse_start();
        feed4(4'b1100);
        for (int i = 0; i < 5; i++) begin
            sin_en = (i == 0 || i == 2); sin = 1'b1;
            tick();
            check("t4_q_m", q_m, 4'b1100); check("t4_q_l", q_l, 4'b0011);
            check("t4_qv", q_valid_m, 1'b1);
            check("t4_cnt", bit_cnt_m, 3'd4);
        end
        sin_en = 1'b0;
        check("t4_ovr_m", overrun_m, 1'b1); check("t4_ovr_l", overrun_l, 1'b1);
        q_ready = 1'b1;
        tick();
        check_both("t4_xfer", 1'b0, 1'b0, 3'd0, 1'b1);
        check("t4_q_kept", q_m, 4'b1100);
        tick(); tick();
        check("t4_ovr_sticky", overrun_m, 1'b1);

        // 5: transfer plus start in the same cycle goes straight to SHIFT
        q_ready = 1'b0;
        sb_m.push_back(4'b1000); sb_l.push_back(4'b0001);
        pulse_start();
        feed4(4'b1000);
        tick();
        sb_m.push_back(4'b0101); sb_l.push_back(4'b1010);
        q_ready = 1'b1; start = 1'b1;
        tick();
        start = 1'b0;
        check_both("t5_b2b", 1'b0, 1'b1, 3'd0, 1'b1);
        feed4(4'b0101);
        check("t5_q_m", q_m, 4'b0101); check("t5_q_l", q_l, 4'b1010);
        check("t5_qv", q_valid_m, 1'b1);
        tick();
        check_both("t5_xfer", 1'b0, 1'b0, 3'd0, 1'b1);

        // 6: abort mid-frame, then clean frames
        pulse_start();
        sin_en = 1'b1; sin = 1'b1;
        tick(); tick();
        check("t6_mid_cnt", bit_cnt_m, 3'd2);
        sin_en = 1'b0; clr = 1'b0;
        tick();
        check_both("t6_abort", 1'b0, 1'b0, 3'd0, 1'b0);
        check("t6_q_m", q_m, 4'b0000); check("t6_q_l", q_l, 4'b0000);
        clr = 1'b1;
        sb_m.push_back(4'b1100); sb_l.push_back(4'b0011);
        pulse_start();
        feed4(4'b1100);
        check("t6_f1_q_m", q_m, 4'b1100); check("t6_f1_q_l", q_l, 4'b0011);
        tick();
        sb_m.push_back(4'b1000); sb_l.push_back(4'b0001);
        pulse_start();
        feed4(4'b1000);
        check("t6_f2_q_l", q_l, 4'b0001); check("t6_f2_q_m", q_m, 4'b1000);
        tick();
        check_both("t6_end", 1'b0, 1'b0, 3'd0, 1'b0);

        tick();
        check("sb_msb_drained", sb_m.size(), 32'd0);
        check("sb_lsb_drained", sb_l.size(), 32'd0);
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule

// File: doc/sipo_frame_ctrl.md
Name: sipo_frame_ctrl

Overview:
Sequencing controller for a serial-in/parallel-out capture path. On a start request it gathers exactly WIDTH qualified serial bits into an internal shift register. It then presents the assembled word on a parallel port with a valid/ready handshake and holds it until the consumer accepts it. It sits between a bit-serial source and any parallel consumer, and flags bits lost while a word is pending.

Parameters:
WIDTH, 4, word length in bits; legal range WIDTH >= 2
MSB_FIRST, 1, 1 = first serial bit lands in q[WIDTH-1]; 0 = first bit lands in q[0]

Ports:
clk  input  1  single system clock, rising-edge active
clr  input  1  synchronous, active-low reset; sampled on the rising edge of clk
start  input  1  begin a new frame (single-cycle pulse or level)
sin  input  1  serial data bit
sin_en  input  1  qualifier: sin is sampled only in cycles where sin_en=1
q  output  WIDTH  assembled parallel word
q_valid  output  1  q holds a complete word
q_ready  input  1  consumer accepts q
busy  output  1  frame in progress or word pending
bit_cnt  output  $clog2(WIDTH+1)  qualified bits captured in the current frame
overrun  output  1  sticky: a qualified bit arrived while a word was pending

Behaviour:
- All state changes occur on the rising edge of clk. There is one clock domain and no async paths.
- Reset (clr=0 at an edge): state goes to IDLE; the shift register, q, q_valid, bit_cnt, overrun and busy all go to 0. Reset has priority over every other input, including mid-frame and during HOLD. A partial frame is discarded.
- State IDLE:
  - busy=0, bit_cnt=0.
  - sin_en is ignored.
  - start=1 -> SHIFT; the shift register and bit_cnt clear.
- State SHIFT:
  - busy=1.
  - Each cycle with sin_en=1 shifts sin in. With MSB_FIRST=1 the shift is left, sin entering the LSB. With MSB_FIRST=0 the shift is right, sin entering the MSB.
  - Each such cycle increments bit_cnt.
  - Cycles with sin_en=0 hold all state.
  - start is ignored.
- Completion: when the WIDTH-th qualified bit is sampled, q loads the full word including that bit. At the same edge q_valid goes to 1, bit_cnt goes to WIDTH, and the state goes to HOLD.
- Latency: q_valid is visible in the cycle following the edge that sampled the last bit.
- State HOLD:
  - busy=1, q_valid=1, and q stays stable until accepted.
  - q_valid=1 and q_ready=1 at an edge is a transfer. The next state is IDLE, with q_valid=0 and bit_cnt=0; q keeps its last value.
  - Transfer with start=1 in the same cycle -> SHIFT directly. q_valid=0, and bit_cnt and the shift register clear. This gives back-to-back frames with no idle cycle.
  - start without q_ready is ignored.
  - sin_en=1 in HOLD drops the bit and sets overrun=1, whether or not a transfer happens in the same cycle.
- overrun is cleared only by reset.
- q_valid is never deasserted without a transfer or reset.
- bit_cnt never exceeds WIDTH. The shift register never wraps into the next frame.

Test Plan:
All scenarios use WIDTH=4, MSB_FIRST=1 unless stated.
1. Hold clr=0 for 2 edges with start=1, sin_en=1, sin toggling -> q=0000, q_valid=0, busy=0, bit_cnt=0, overrun=0. Release clr -> still IDLE until start.
2. Pulse start, then 4 consecutive cycles of sin_en=1 with sin=1,0,1,1, and q_ready=1:
   - q_valid is high for exactly one cycle, starting the cycle after the 4th bit, with q=1011.
   - busy falls on the following edge.
3. Pulse start, then sin_en=1,0,0,1,1,0,1 with sin=0,x,x,1,1,x,0 -> bit_cnt steps 1,1,1,2,3,3,4 and q=0110.
4. After a word completes, hold q_ready=0 for 5 cycles while pulsing sin_en=1 twice:
   - q stays stable, q_valid=1 and overrun=1.
   - Then assert q_ready -> IDLE; overrun stays 1 until clr=0.
5. In HOLD, assert start=1 and q_ready=1 together -> next state SHIFT with bit_cnt=0 and no IDLE cycle. Feed 0,1,0,1 -> q=0101.
6. Drive clr=0 after 2 bits of a frame -> all outputs 0 at that edge. A new frame with bits 1,1,0,0 yields q=1100 with no residue from the aborted frame.
   - Repeat with MSB_FIRST=0 and bits 1,0,0,0 -> q=0001.
